fft_stage_scheduler: RTL and testbench

Sequencer for the radix-2 DIT FFT core. It walks all stages and butterflies of an N = 2^FFT_N transform and drives the twiddle-ROM bridge's request port (`tact_rom`, `ta_rom`, `evenOdd`, `ifft`). It also emits butterfly data-RAM addresses delayed so they arrive in the same cycle as the bridge's twiddle output. It sits between the FFT top-level control (start/done) and the bridge plus butterfly datapath.

---
 rtl/fft_sched_pkg.sv | 14 +
 rtl/fft_bf_addr_gen.sv | 33 +++
 rtl/fft_stage_scheduler.sv | 167 ++++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the radix-2 FFT stage scheduler.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_FLUSH = 2'd3
    } sched_state_e;

    localparam int PAIR_LEN   = 2;
    localparam int BRIDGE_LAT = 3;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly operand addresses and twiddle index for butterfly j of stage s.
module fft_bf_addr_gen #(
    parameter int FFT_N = 10
) (
    input  logic [$clog2(FFT_N)-1:0] i_s,
    input  logic [FFT_N-2:0]         i_j,
    output logic [FFT_N-1:0]         o_addr_a,
    output logic [FFT_N-1:0]         o_addr_b,
    output logic [FFT_N-2:0]         o_ta
);

    localparam int SW = $clog2(FFT_N);

    logic [FFT_N-1:0] w_j_ext;
    logic [FFT_N-1:0] w_half;
    logic [FFT_N-1:0] w_mask_lo;
    logic [FFT_N-2:0] w_k;
    logic [SW-1:0]    w_shift;

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        w_j_ext   = {1'b0, i_j};
        w_half    = FFT_N'(1) << i_s;
        w_mask_lo = w_half - 1'b1;
        w_k       = i_j & w_mask_lo[FFT_N-2:0];
        w_shift   = SW'(FFT_N - 1) - i_s;
        // Group index g sits above bit s; inserting a zero at bit s yields g*2*half + k.
        o_addr_a  = ((w_j_ext & ~w_mask_lo) << 1) | (w_j_ext & w_mask_lo);
        o_addr_b  = o_addr_a | w_half;
        o_ta      = w_k << w_shift;
    end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Walks all stages/butterflies of the FFT, drives twiddle requests and emits
// butterfly addresses delayed to line up with the bridge's twiddle output.
module fft_stage_scheduler
    import fft_sched_pkg::*;
#(
    parameter int FFT_N   = 10,
    parameter int GAP_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     ifft_in,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     tact_rom,
    output logic [FFT_N-2:0]         ta_rom,
    output logic                     evenOdd,
    output logic                     ifft,
    output logic [$clog2(FFT_N)-1:0] stage,
    output logic                     bf_valid,
    output logic [FFT_N-1:0]         addr_a,
    output logic [FFT_N-1:0]         addr_b
);

    localparam int SW = $clog2(FFT_N);
    localparam int JW = FFT_N - 1;
    localparam int CW = $clog2(GAP_CYC + BRIDGE_LAT) + 1;

    localparam logic [JW-1:0] J_LAST     = '1;
    localparam logic [SW-1:0] S_LAST     = SW'(FFT_N - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] FLUSH_DONE = CW'(BRIDGE_LAT - 2);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(BRIDGE_LAT - 1);

    sched_state_e  r_state;
    logic [SW-1:0] r_s;
    logic [JW-1:0] r_j;
    logic [CW-1:0] r_cnt;
    logic          r_tact;
    logic          r_eo;
    logic          r_busy;
    logic          r_done;
    logic          r_ifft;

    logic             r_pv [BRIDGE_LAT];
    logic [FFT_N-1:0] r_pa [BRIDGE_LAT];
    logic [FFT_N-1:0] r_pb [BRIDGE_LAT];
    logic [SW-1:0]    r_ps [BRIDGE_LAT];

    logic [FFT_N-1:0] w_addr_a;
    logic [FFT_N-1:0] w_addr_b;
    logic [JW-1:0]    w_ta;

    fft_bf_addr_gen #(.FFT_N(FFT_N)) u_addr_gen (
        .i_s      (r_s),
        .i_j      (r_j),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_ta     (w_ta)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_tact  <= 1'b0;
            r_eo    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ifft  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ifft  <= ifft_in;
                        r_s     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_tact  <= !hold;
                        r_eo    <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_tact && !r_eo) begin
                        r_eo <= 1'b1;
                    end else if (r_tact) begin
                        r_eo <= 1'b0;
                        if (r_j == J_LAST) begin
                            r_tact  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= (r_s == S_LAST) ? S_FLUSH : S_GAP;
                        end else begin
                            r_j    <= r_j + 1'b1;
                            r_tact <= !hold;
                        end
                    end else begin
                        // Held even slot: retry, sampling hold again.
                        r_tact <= !hold;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_s     <= r_s + 1'b1;
                        r_j     <= '0;
                        r_tact  <= !hold;
                        r_eo    <= 1'b0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == FLUSH_DONE) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    if (r_cnt == FLUSH_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the delay line is reset (not left as uninitialised storage) so no stale bf_valid survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BRIDGE_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pb[i] <= '0;
                r_ps[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_tact && !r_eo;
            r_pa[0] <= w_addr_a;
            r_pb[0] <= w_addr_b;
            r_ps[0] <= r_s;
            for (int i = 1; i < BRIDGE_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
                r_ps[i] <= r_ps[i-1];
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign tact_rom = r_tact;
    assign evenOdd  = r_eo;
    assign ta_rom   = r_tact ? w_ta : '0;
    assign ifft     = r_ifft;
    assign bf_valid = r_pv[BRIDGE_LAT-1];
    assign addr_a   = r_pa[BRIDGE_LAT-1];
    assign addr_b   = r_pb[BRIDGE_LAT-1];
    assign stage    = r_ps[BRIDGE_LAT-1];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Bench for fft_stage_scheduler (FFT_N=3, GAP_CYC=4): slot-plan reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_fft_stage_scheduler;

    localparam int FFT_N   = 3;
    localparam int GAP_CYC = 4;
    localparam int NB      = 1 << (FFT_N - 1);

    logic clk = 1'b0;
    logic reset_n, start, ifft_in, hold;
    logic busy, done, tact_rom, evenOdd, ifft, bf_valid;
    logic [FFT_N-2:0] ta_rom;
    logic [1:0]       stage;
    logic [FFT_N-1:0] addr_a, addr_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fft_stage_scheduler #(.FFT_N(FFT_N), .GAP_CYC(GAP_CYC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ifft_in  (ifft_in),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .tact_rom (tact_rom),
        .ta_rom   (ta_rom),
        .evenOdd  (evenOdd),
        .ifft     (ifft),
        .stage    (stage),
        .bf_valid (bf_valid),
        .addr_a   (addr_a),
        .addr_b   (addr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a per-transform slot plan ----------------
    typedef enum int {K_EVEN, K_ODD, K_GAP, K_FLUSH, K_DONE} kind_e;
    typedef struct { kind_e k; int s; int j; } slot_t;
    typedef struct { int due; int a; int b; int s; } bf_t;

    slot_t plan[$];
    bf_t   pend[$];
    bit    m_run = 1'b0;
    int    mcyc  = 0;
    logic  e_busy = 0, e_done = 0, e_tact = 0, e_eo = 0, e_ifft = 0, e_bf = 0;
    int    e_ta = 0, e_a = 0, e_b = 0, e_s = 0;

    function automatic int m_addr_a(input int s, input int j);
        int half = 1 << s;
        return (j / half) * 2 * half + (j % half);
    endfunction

    function automatic int m_ta(input int s, input int j);
        return ((j % (1 << s)) << (FFT_N - 1 - s)) % NB;
    endfunction

    task automatic build_plan();
        plan.delete();
        for (int s = 0; s < FFT_N; s++) begin
            for (int j = 0; j < NB; j++) begin
                plan.push_back('{k: K_EVEN, s: s, j: j});
                plan.push_back('{k: K_ODD,  s: s, j: j});
            end
            if (s < FFT_N - 1)
                repeat (GAP_CYC) plan.push_back('{k: K_GAP, s: s, j: 0});
        end
        repeat (2) plan.push_back('{k: K_FLUSH, s: 0, j: 0});
        plan.push_back('{k: K_DONE, s: 0, j: 0});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                plan.delete();
                pend.delete();
                m_run = 1'b0;
                mcyc  = 0;
                e_busy = 0; e_done = 0; e_tact = 0; e_eo = 0; e_ifft = 0; e_bf = 0;
                e_ta = 0; e_a = 0; e_b = 0; e_s = 0;
            end else begin
                mcyc++;
                e_tact = 0; e_eo = 0; e_ta = 0; e_done = 0; e_bf = 0;
                if (m_run && plan.size() == 0) begin
                    m_run  = 1'b0;
                    e_busy = 0;
                end else if (!m_run && start) begin
                    e_ifft = ifft_in;
                    build_plan();
                    m_run = 1'b1;
                end
                if (m_run && plan.size() > 0) begin
                    if (plan[0].k == K_EVEN && hold) begin
                        e_busy = 1;
                    end else begin
                        slot_t sl;
                        sl     = plan.pop_front();
                        e_busy = (sl.k != K_DONE);
                        e_done = (sl.k == K_DONE);
                        if (sl.k == K_EVEN || sl.k == K_ODD) begin
                            e_tact = 1;
                            e_eo   = (sl.k == K_ODD);
                            e_ta   = m_ta(sl.s, sl.j);
                        end
                        if (sl.k == K_EVEN)
                            pend.push_back('{due: mcyc + 3, a: m_addr_a(sl.s, sl.j),
                                             b: m_addr_a(sl.s, sl.j) + (1 << sl.s), s: sl.s});
                    end
                end
                if (pend.size() > 0 && pend[0].due == mcyc) begin
                    bf_t p;
                    p    = pend.pop_front();
                    e_bf = 1; e_a = p.a; e_b = p.b; e_s = p.s;
                end
            end
        end
    end

    // Compare process: every cycle, just after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("ctrl{busy,done,tact,eo,ifft,bfv}",
                      {busy, done, tact_rom, evenOdd, ifft, bf_valid},
                      {e_busy, e_done, e_tact, e_eo, e_ifft, e_bf});
                check("ta_rom", ta_rom, e_ta);
                if (e_bf)
                    check("bf{stage,a,b}", {stage, addr_a, addr_b},
                          {e_s[1:0], e_a[FFT_N-1:0], e_b[FFT_N-1:0]});
            end
        end
    end

    // ---------------- directed runs ----------------
    int qa[$], qb[$], qt[$];
    int exp_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // Caller is at a falling edge with the DUT idle; start goes high for cycle 0.
    task automatic run_dir(input bit ifv, input int hlo, input int hhi, input int start_again,
                           output int done_cyc, output int first_bf, output int n_tact,
                           output int ifft_bad);
        done_cyc = -1; first_bf = -1; n_tact = 0; ifft_bad = 0;
        qa.delete(); qb.delete(); qt.delete();
        start   = 1'b1;
        ifft_in = ifv;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            start   = (c == start_again);
            ifft_in = (c >= 6) ? ~ifv : ifv;
            hold    = (c >= hlo && c <= hhi);
            if (bf_valid) begin
                if (first_bf < 0) first_bf = c;
                qa.push_back(int'(addr_a));
                qb.push_back(int'(addr_b));
            end
            if (tact_rom && !evenOdd) qt.push_back(int'(ta_rom));
            if (tact_rom) n_tact++;
            if (busy && ifft !== ifv) ifft_bad++;
            if (done) done_cyc = c;
        end
        start = 1'b0;
        hold  = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_bf_count"}, qa.size(), 12);
        check({tag, "_ta_count"}, qt.size(), 12);
        for (int i = 0; i < 12 && i < qa.size() && i < qt.size(); i++) begin
            check($sformatf("%s_addr_a[%0d]", tag, i), qa[i], exp_a[i]);
            check($sformatf("%s_addr_b[%0d]", tag, i), qb[i], exp_b[i]);
            check($sformatf("%s_ta_rom[%0d]", tag, i), qt[i], exp_t[i]);
        end
    endtask

    initial begin
        int dc, fb, nt, ib, stray;
        reset_n = 1'b0; start = 1'b0; ifft_in = 1'b0; hold = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {busy, done, tact_rom, evenOdd, ifft, bf_valid, ta_rom, stage, addr_a, addr_b}, '0);
        reset_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (tact_rom || busy) stray++;
        end
        check("idle_no_tact", stray, 0);

        // Plain transform.
        run_dir(1'b0, -1, -1, -1, dc, fb, nt, ib);
        check("run1_first_bf", fb, 4);
        check("run1_done", dc, 35);
        check("run1_tact_cycles", nt, 24);
        check_seq("run1");
        @(negedge clk);

        // Direction latch with ifft_in toggling and an ignored start while busy.
        run_dir(1'b1, -1, -1, 10, dc, fb, nt, ib);
        check("run2_done", dc, 35);
        check("run2_ifft_latched", ib, 0);
        @(negedge clk);

        // Hold raised in an even cycle of stage 1: the odd half completes, two slots stall.
        run_dir(1'b0, 13, 15, -1, dc, fb, nt, ib);
        check("run3_done_hold", dc, 37);
        check("run3_tact_cycles", nt, 24);
        check_seq("run3");
        @(negedge clk);

        // Reset mid-run.
        start = 1'b1; ifft_in = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {busy, done, tact_rom, evenOdd, ifft, bf_valid, ta_rom, stage, addr_a, addr_b}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bf_valid || tact_rom || busy) stray++;
        end
        check("post_reset_quiet", stray, 0);
        run_dir(1'b0, -1, -1, -1, dc, fb, nt, ib);
        check("run4_done", dc, 35);
        check_seq("run4");

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 7) == 0);
            ifft_in = 1'($urandom_range(0, 1));
            hold    = ($urandom_range(0, 3) == 0);
            reset_n = !($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        start = 1'b0; hold = 1'b0; reset_n = 1'b1;
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
